// File: rtl/inject_queue_pkg.sv
// Shared router constants for the PE inject path: channel count, flit width, starve semantics.
package inject_queue_pkg;

  localparam int GLOBAL_NUM_CHANNEL  = 5;
  localparam int GLOBAL_FLIT_WIDTH   = 32;
  localparam int GLOBAL_STARVE_LIMIT = 16;
  localparam int STARVE_CNT_WIDTH    = 8;

  typedef logic [STARVE_CNT_WIDTH-1:0] starveCnt_t;

  // The router arbiter uses the same test, so saturation and flagging always agree.
  function automatic logic starveAtLimit(input starveCnt_t cnt, input int limit);
    return cnt == starveCnt_t'(limit);
  endfunction

endpackage

// File: rtl/inject_fifo_mem.sv
// Inject queue storage: DEPTH x FLIT_WIDTH registers, one synchronous write port, one async read port.
// Contents are never reset; the control logic masks stale entries through its valid signal.
module inject_fifo_mem
  import inject_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int FLIT_WIDTH = GLOBAL_FLIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [FLIT_WIDTH-1:0]    wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [FLIT_WIDTH-1:0]    rdData
);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/inject_queue.sv
// PE-to-router inject FIFO: 1-cycle write-to-head, zero-latency head visibility, pops on any grant.
// Ready depends only on registered occupancy (a same-cycle pop does not free a slot); starveOut flags a long-denied head.
module inject_queue
  import inject_queue_pkg::*;
#(
  parameter int NUM_CHANNEL  = GLOBAL_NUM_CHANNEL,
  parameter int FLIT_WIDTH   = GLOBAL_FLIT_WIDTH,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = GLOBAL_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FLIT_WIDTH-1:0]    peFlitIn,
  input  logic                     peValidIn,
  output logic                     peReadyOut,
  input  logic [NUM_CHANNEL-1:0]   localInjectGrant,
  output logic                     injectValidOut,
  output logic [FLIT_WIDTH-1:0]    injectFlitOut,
  output logic [$clog2(DEPTH):0]   occupancyOut,
  output logic                     starveOut
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] occupancy;
  starveCnt_t       starveCnt;
  starveCnt_t       starveNext;
  logic             push;
  logic             pop;

  assign peReadyOut     = occupancy < OCC_W'(DEPTH);
  assign injectValidOut = occupancy != '0;
  assign occupancyOut   = occupancy;

  assign push = peValidIn & peReadyOut;
  // A grant with nothing queued must not move anything, hence the valid qualifier.
  assign pop  = injectValidOut & (|localInjectGrant);

  always_comb begin
    starveNext = starveCnt;
    if (pop || !injectValidOut) begin
      starveNext = '0;
    end else if (!starveAtLimit(starveCnt, STARVE_LIMIT)) begin
      starveNext = starveCnt + starveCnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
      starveCnt <= '0;
      starveOut <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
      starveCnt <= starveNext;
      starveOut <= starveAtLimit(starveNext, STARVE_LIMIT);
    end
  end

  inject_fifo_mem #(
    .DEPTH      (DEPTH),
    .FLIT_WIDTH (FLIT_WIDTH)
  ) uMem (
    .clk    (clk),
    .wrEn   (push),
    .wrAddr (wrPtr),
    .wrData (peFlitIn),
    .rdAddr (rdPtr),
    .rdData (injectFlitOut)
  );

endmodule

// File: tb/tb_inject_queue.sv
// Bench for inject_queue: directed vector table, hand-written corner sequences, and a randomized run against a queue model.
module tb_inject_queue;

  localparam int NC    = 5;
  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 16;
  localparam int OW    = 3;

  logic          clk;
  logic          reset;
  logic [FW-1:0] peFlitIn;
  logic          peValidIn;
  logic          peReadyOut;
  logic [NC-1:0] grant;
  logic          injectValidOut;
  logic [FW-1:0] injectFlitOut;
  logic [OW-1:0] occupancyOut;
  logic          starveOut;

  int nChecks = 0;
  int nFails  = 0;

  inject_queue #(
    .NUM_CHANNEL  (NC),
    .FLIT_WIDTH   (FW),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .peFlitIn         (peFlitIn),
    .peValidIn        (peValidIn),
    .peReadyOut       (peReadyOut),
    .localInjectGrant (grant),
    .injectValidOut   (injectValidOut),
    .injectFlitOut    (injectFlitOut),
    .occupancyOut     (occupancyOut),
    .starveOut        (starveOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [FW-1:0] f;
    logic [NC-1:0] g;
    int            eOcc;
    logic          eStarve;
    logic [FW-1:0] eHead;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkState(input string tag, input int eOcc, input logic eStarve, input logic [FW-1:0] eHead);
    check({tag, " ready"}, 32'(peReadyOut), 32'(eOcc < DEPTH));
    check({tag, " valid"}, 32'(injectValidOut), 32'(eOcc != 0));
    check({tag, " occ"}, 32'(occupancyOut), 32'(eOcc));
    check({tag, " starve"}, 32'(starveOut), 32'(eStarve));
    if (eOcc != 0) check({tag, " head"}, 32'(injectFlitOut), 32'(eHead));
  endtask

  task automatic drive(input logic v, input logic [FW-1:0] f, input logic [NC-1:0] g);
    peValidIn = v;
    peFlitIn  = f;
    grant     = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    drive(1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  logic [FW-1:0] q[$];
  int            sc;
  logic          mPop;
  logic          mPush;
  int            sizeBefore;
  logic [FW-1:0] rf;
  logic          rv;
  logic [NC-1:0] rg;

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0);

    // Fill, pop with one-hot/multi-hot grants, blocked push while full, grants on an empty queue.
    tbl[0]  = '{1'b1, 32'hA, 5'b00000, 0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'hB, 5'b00000, 1, 1'b0, 32'hA};
    tbl[2]  = '{1'b1, 32'hC, 5'b00000, 2, 1'b0, 32'hA};
    tbl[3]  = '{1'b0, 32'h0, 5'b00100, 3, 1'b0, 32'hA};
    tbl[4]  = '{1'b1, 32'hD, 5'b00000, 2, 1'b0, 32'hB};
    tbl[5]  = '{1'b1, 32'hE, 5'b00000, 3, 1'b0, 32'hB};
    tbl[6]  = '{1'b1, 32'hF, 5'b00001, 4, 1'b0, 32'hB};
    tbl[7]  = '{1'b0, 32'h0, 5'b11111, 3, 1'b0, 32'hC};
    tbl[8]  = '{1'b0, 32'h0, 5'b00010, 2, 1'b0, 32'hD};
    tbl[9]  = '{1'b0, 32'h0, 5'b01000, 1, 1'b0, 32'hE};
    for (int i = 10; i < 15; i++) tbl[i] = '{1'b0, 32'h0, 5'b11111, 0, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 32'h0, 5'b00000, 0, 1'b0, 32'h0};

    doReset();
    for (int i = 0; i < 16; i++) begin
      checkState($sformatf("vec%0d", i), tbl[i].eOcc, tbl[i].eStarve, tbl[i].eHead);
      drive(tbl[i].v, tbl[i].f, tbl[i].g);
      tick();
    end

    // Starvation: one flit held with no grant, flag at LIMIT denied cycles, cleared by a pop.
    doReset();
    drive(1'b1, 32'h5A5A, '0);
    tick();
    checkState("starve0", 1, 1'b0, 32'h5A5A);
    for (int k = 1; k <= LIMIT + 3; k++) begin
      drive(1'b0, '0, '0);
      tick();
      checkState($sformatf("starve%0d", k), 1, k >= LIMIT, 32'h5A5A);
    end
    drive(1'b0, '0, 5'b00010);
    tick();
    checkState("starvePop", 0, 1'b0, 32'h0);

    // Steady push+pop at occupancy 2 across several pointer wraps.
    doReset();
    drive(1'b1, 32'h100, '0);
    tick();
    drive(1'b1, 32'h101, '0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(32'h102 + i), 5'b00001);
      checkState($sformatf("wrap%0d", i), 2, 1'b0, 32'(32'h100 + i));
      tick();
    end
    drive(1'b0, '0, '0);
    checkState("wrapEnd", 2, 1'b0, 32'h10A);

    // Asynchronous reset mid-burst: outputs at reset values before the next clock edge.
    doReset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h200 + i), '0);
      tick();
    end
    drive(1'b0, '0, '0);
    checkState("preArst", 3, 1'b0, 32'h200);
    #2;
    reset = 1'b1;
    #1;
    checkState("arst", 0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkState("postArst", 0, 1'b0, 32'h0);

    // Randomized traffic against a queue model; alternating phases favour starvation.
    doReset();
    q.delete();
    sc = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      checkState($sformatf("rnd%0d", cyc), q.size(), sc >= LIMIT, (q.size() != 0) ? q[0] : '0);
      rv = 1'($urandom_range(0, 1));
      rf = $urandom;
      if ($urandom_range(0, 99) < (((cyc / 80) % 2 == 1) ? 97 : 50)) rg = '0;
      else rg = NC'($urandom_range(1, 31));
      drive(rv, rf, rg);
      sizeBefore = q.size();
      mPop  = (sizeBefore > 0) && (rg != '0);
      mPush = rv && (sizeBefore < DEPTH);
      if (mPop) void'(q.pop_front());
      if (mPush) q.push_back(rf);
      if (mPop || sizeBefore == 0) sc = 0;
      else if (sc < LIMIT) sc = sc + 1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/inject_queue.md
INJECT_QUEUE -- requirements
Module: inject_queue

Interface
REQ-001 Parameter: NUM_CHANNEL, default `NUM_CHANNEL from global.vh (5), number of router channels.
REQ-002 Parameter: FLIT_WIDTH, default `FLIT_WIDTH from global.vh, flit width in bits.
REQ-003 Parameter: DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-004 Parameter: STARVE_LIMIT, default 16, consecutive denied cycles before starve is flagged; range 1..255.
REQ-005 Port: clk  in  1  the block's single clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: peFlitIn  in  FLIT_WIDTH  flit offered by the local PE.
REQ-008 Port: peValidIn  in  1  peFlitIn valid.
REQ-009 Port: peReadyOut  out  1  queue accepts a flit this cycle.
REQ-010 Port: localInjectGrant  in  NUM_CHANNEL  one-hot channel grant from the eject/inject grant stage; all-zero means no free slot.
REQ-011 Port: injectValidOut  out  1  head flit present for injection.
REQ-012 Port: injectFlitOut  out  FLIT_WIDTH  head flit.
REQ-013 Port: occupancyOut  out  clog2(DEPTH)+1  current entry count.
REQ-014 Port: starveOut  out  1  head has been denied for STARVE_LIMIT or more consecutive cycles.

Function
REQ-015 FIFO order, DEPTH entries; read/write pointers wrap modulo DEPTH.
REQ-016 peReadyOut = (occupancy < DEPTH), derived from registered state only; a pop in the same cycle does not raise it.
REQ-017 Push when peValidIn & peReadyOut; the flit is written at the write pointer on that edge.
REQ-018 injectValidOut = (occupancy != 0); injectFlitOut = entry at the read pointer; both combinational from state, zero-latency head visibility.
REQ-019 Pop when injectValidOut & |localInjectGrant; the head is removed on that edge.
REQ-020 A grant while empty is ignored: no pointer, occupancy or counter change.
REQ-021 A multi-hot grant pops exactly one flit, the same as one-hot.
REQ-022 Push and pop in the same cycle: occupancy unchanged, both pointers advance.
REQ-023 Push into an empty queue: the flit is visible on injectFlitOut the next cycle (1-cycle write-to-head latency).
REQ-024 Starve counter, 8-bit: increments each cycle injectValidOut & ~|localInjectGrant; saturates at STARVE_LIMIT; clears on pop or when empty.
REQ-025 starveOut = (starve counter == STARVE_LIMIT), registered.
REQ-026 Overflow impossible by construction; underflow impossible per REQ-020.

Reset
REQ-027 On reset: pointers 0, occupancy 0, starve counter 0; therefore peReadyOut=1, injectValidOut=0, starveOut=0, occupancyOut=0.
REQ-028 Reset mid-operation discards all queued flits; storage contents need no reset; injectFlitOut is don't-care while injectValidOut=0.
REQ-029 Reset is asynchronous on assertion and takes effect immediately, regardless of clk.

Structure
REQ-030 NUM_CHANNEL and FLIT_WIDTH come from the shared global.vh; no local redefinition.
REQ-031 STARVE_LIMIT default and counter width live in global.vh, so the router arbiter can reference starveOut semantics.
REQ-032 One sub-module: inject_fifo_mem (DEPTH x FLIT_WIDTH register array, one write port, one async read port); control stays in inject_queue.

Verification
REQ-033 Reset, then push A, B, C with grant=0 -> occupancy 3, head=A, peReadyOut=1; grant=00100 for one cycle -> head=B, occupancy 2.
REQ-034 Fill 4 flits with grant=0 -> peReadyOut=0; push attempt with grant=00001 in the same cycle -> flit not accepted, occupancy 3 next cycle.
REQ-035 Empty queue, grant=11111 for 5 cycles -> no state change, injectValidOut=0, starveOut=0.
REQ-036 One flit queued, grant=0 for 16 cycles -> starveOut=1 on cycle 16 and held; grant=00010 -> pop, starveOut=0 next cycle.
REQ-037 Occupancy 2, push and grant every cycle for 10 cycles -> occupancy stays 2, output order matches input order across pointer wrap.
REQ-038 Assert reset asynchronously mid-burst with occupancy 3 -> all outputs at reset values before the next clk edge.
